// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the serial pattern detector.
package seq_det_pkg;

    localparam int unsigned PAT_LEN_DEF = 4;
    localparam int unsigned CNT_W_DEF   = 8;
    localparam logic [PAT_LEN_DEF-1:0] PAT_DEFAULT_DEF = 4'b1011;

    // What the detector does on a given edge once reset is released.
    typedef enum logic [1:0] {
        ActHold,
        ActLoad,
        ActShift
    } seq_act_e;

    // The fill counter must be able to hold the value pat_len itself.
    function automatic int unsigned fill_width(input int unsigned pat_len);
        return $clog2(pat_len + 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Generic saturating up-counter with synchronous clear.
// Clear and increment on the same edge yield 1, so that event is not lost.
module sat_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_d, count_q;

    // Next count: clear wins over hold, and saturation stops at all ones.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = inc_i ? CNT_W'(1) : '0;
        end else if (inc_i && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised serial bit-pattern detector with loadable pattern,
// overlapping/non-overlapping detection and a saturating match counter.
// Optional don't-care mask input enabled by defining SEQ_DET_MASK_EN.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int unsigned          PAT_LEN     = PAT_LEN_DEF,
    parameter logic [PAT_LEN-1:0]   PAT_DEFAULT = PAT_DEFAULT_DEF,
    parameter bit                   OVERLAP     = 1'b1,
    parameter int unsigned          CNT_W       = CNT_W_DEF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               sequence_in,
    input  logic               in_valid,
    input  logic [PAT_LEN-1:0] pattern,
    input  logic               pattern_load,
    input  logic               count_clr,
`ifdef SEQ_DET_MASK_EN
    input  logic [PAT_LEN-1:0] pattern_mask,
`endif
    output logic               detector_out,
    output logic [CNT_W-1:0]   match_count,
    output logic [PAT_LEN-1:0] pat_active
);

    localparam int unsigned          FILL_W   = fill_width(PAT_LEN);
    localparam logic [FILL_W-1:0]    FILL_MAX = FILL_W'(PAT_LEN);
    // One more bit completes a full window once fill reaches this value.
    localparam logic [FILL_W-1:0]    FILL_ARM = FILL_W'(PAT_LEN - 1);

    logic [PAT_LEN-1:0] hist_d, hist_q;
    logic [FILL_W-1:0]  fill_d, fill_q;
    logic [PAT_LEN-1:0] pat_d, pat_q;
    logic               det_d, det_q;
    logic [PAT_LEN-1:0] mask;
    logic [PAT_LEN-1:0] hist_n;
    logic               hit;
    seq_act_e           act;

`ifdef SEQ_DET_MASK_EN
    logic [PAT_LEN-1:0] mask_q;

    // Mask is captured together with the pattern; all ones means exact compare.
    always_ff @(posedge clock) begin
        if (!reset) begin
            mask_q <= '1;
        end else if (pattern_load) begin
            mask_q <= pattern_mask;
        end
    end

    assign mask = mask_q;
`else
    assign mask = '1;
`endif

    // Decode the edge action: load beats a valid data bit.
    always_comb begin
        act = ActHold;
        if (pattern_load) begin
            act = ActLoad;
        end else if (in_valid) begin
            act = ActShift;
        end
    end

    assign hist_n = {hist_q[PAT_LEN-2:0], sequence_in};
    assign hit    = (act == ActShift) && (fill_q >= FILL_ARM) &&
                    ((hist_n & mask) == (pat_q & mask));

    // Next-state for history, fill level, active pattern and match pulse.
    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        pat_d  = pat_q;
        det_d  = 1'b0;
        unique case (act)
            ActLoad: begin
                pat_d  = pattern;
                hist_d = '0;
                fill_d = '0;
            end
            ActShift: begin
                hist_d = hist_n;
                det_d  = hit;
                fill_d = (fill_q == FILL_MAX) ? fill_q : fill_q + 1'b1;
                if (!OVERLAP && hit) begin
                    hist_d = '0;
                    fill_d = '0;
                end
            end
            default: begin
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            hist_q <= '0;
            fill_q <= '0;
            pat_q  <= PAT_DEFAULT;
            det_q  <= 1'b0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            pat_q  <= pat_d;
            det_q  <= det_d;
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_match_cnt (
        .clk_i   (clock),
        .rst_ni  (reset),
        .clr_i   (count_clr),
        .inc_i   (hit),
        .count_o (match_count)
    );

    assign detector_out = det_q;
    assign pat_active   = pat_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: three instances (overlap, non-overlap,
// 2-bit counter) share one directed stimulus stream. A queue-of-bits model
// predicts every output each cycle; literal checks pin the expected story.
module tb_seq_detector_param;

    localparam int BUF = 256;

    logic       clock;
    logic       reset;
    logic       sequence_in;
    logic       in_valid;
    logic [3:0] pattern;
    logic       pattern_load;
    logic       count_clr;

    logic       det_ov, det_no, det_c2;
    logic [7:0] cnt_ov, cnt_no;
    logic [1:0] cnt_c2;
    logic [3:0] pat_ov, pat_no, pat_c2;

    int checks   = 0;
    int failures = 0;

`ifdef SEQ_DET_MASK_EN
    logic [3:0] pattern_mask = 4'b1111;
`endif

    seq_detector_param #(.OVERLAP(1'b1)) u_ov (
        .clock(clock), .reset(reset), .sequence_in(sequence_in), .in_valid(in_valid),
        .pattern(pattern), .pattern_load(pattern_load), .count_clr(count_clr),
`ifdef SEQ_DET_MASK_EN
        .pattern_mask(pattern_mask),
`endif
        .detector_out(det_ov), .match_count(cnt_ov), .pat_active(pat_ov)
    );

    seq_detector_param #(.OVERLAP(1'b0)) u_no (
        .clock(clock), .reset(reset), .sequence_in(sequence_in), .in_valid(in_valid),
        .pattern(pattern), .pattern_load(pattern_load), .count_clr(count_clr),
`ifdef SEQ_DET_MASK_EN
        .pattern_mask(pattern_mask),
`endif
        .detector_out(det_no), .match_count(cnt_no), .pat_active(pat_no)
    );

    seq_detector_param #(.OVERLAP(1'b1), .CNT_W(2)) u_c2 (
        .clock(clock), .reset(reset), .sequence_in(sequence_in), .in_valid(in_valid),
        .pattern(pattern), .pattern_load(pattern_load), .count_clr(count_clr),
`ifdef SEQ_DET_MASK_EN
        .pattern_mask(pattern_mask),
`endif
        .detector_out(det_c2), .match_count(cnt_c2), .pat_active(pat_c2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each instance keeps the list of bits received since the last clear
    // (reset, load, or a non-overlapping hit); a hit means the newest
    // four bits spell the pattern, first-received bit as MSB.
    bit       model_ok = 1'b0;
    bit       m_buf [3][BUF];
    int       m_len [3];
    int       m_cnt [3];
    bit       m_det [3];
    bit [3:0] m_pat;

    function automatic bit ovl_of(input int i);
        return i != 1;
    endfunction

    function automatic int max_of(input int i);
        return (i == 2) ? 3 : 255;
    endfunction

    always @(posedge clock) begin
        if (!reset) begin
            model_ok = 1'b1;
            m_pat    = 4'b1011;
            for (int i = 0; i < 3; i++) begin
                m_len[i] = 0;
                m_cnt[i] = 0;
                m_det[i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                bit hit;
                hit = 1'b0;
                if (pattern_load) begin
                    m_len[i] = 0;
                end else if (in_valid) begin
                    if (m_len[i] == BUF) begin
                        for (int k = 1; k < BUF; k++) m_buf[i][k-1] = m_buf[i][k];
                        m_len[i]--;
                    end
                    m_buf[i][m_len[i]] = sequence_in;
                    m_len[i]++;
                    if (m_len[i] >= 4) begin
                        hit = 1'b1;
                        for (int k = 0; k < 4; k++)
                            if (m_buf[i][m_len[i]-4+k] != m_pat[3-k]) hit = 1'b0;
                    end
                    if (hit && !ovl_of(i)) m_len[i] = 0;
                end
                m_det[i] = hit;
                if (count_clr) m_cnt[i] = hit ? 1 : 0;
                else if (hit && m_cnt[i] < max_of(i)) m_cnt[i]++;
            end
            if (pattern_load) m_pat = pattern;
        end
    end

    // ---------------- per-cycle compare ----------------
    logic       det_a [3];
    logic [7:0] cnt_a [3];
    logic [3:0] pat_a [3];
    assign det_a[0] = det_ov;
    assign det_a[1] = det_no;
    assign det_a[2] = det_c2;
    assign cnt_a[0] = cnt_ov;
    assign cnt_a[1] = cnt_no;
    assign cnt_a[2] = {6'b0, cnt_c2};
    assign pat_a[0] = pat_ov;
    assign pat_a[1] = pat_no;
    assign pat_a[2] = pat_c2;

    always @(negedge clock) begin
        if (model_ok) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("model_det[%0d]", i), 32'(det_a[i]), 32'(m_det[i]));
                chk($sformatf("model_cnt[%0d]", i), 32'(cnt_a[i]), 32'(m_cnt[i]));
                chk($sformatf("model_pat[%0d]", i), 32'(pat_a[i]), 32'(m_pat));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input bit b);
        sequence_in = b;
        in_valid    = 1'b1;
        tick();
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        in_valid = 1'b0;
        tick();
        reset    = 1'b1;
    endtask

    logic [6:0] t1_bits;
    logic [6:0] t1_exp_ov;
    logic [6:0] t1_exp_no;

    initial begin
        reset        = 1'b0;
        sequence_in  = 1'b0;
        in_valid     = 1'b0;
        pattern      = 4'b0000;
        pattern_load = 1'b0;
        count_clr    = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        chk("rst_pat", 32'(pat_ov), 32'h0000000b);
        chk("rst_cnt", 32'(cnt_ov), 32'd0);
        chk("rst_det", 32'(det_ov), 32'd0);

        // Test 1/2: 1,0,1,1,0,1,1 on overlap and non-overlap instances.
        t1_bits   = 7'b1011011;
        t1_exp_ov = 7'b0001001;
        t1_exp_no = 7'b0001000;
        for (int i = 6; i >= 0; i--) begin
            send(t1_bits[i]);
            chk($sformatf("t1_ov_bit%0d", 7 - i), 32'(det_ov), 32'(t1_exp_ov[i]));
            chk($sformatf("t2_no_bit%0d", 7 - i), 32'(det_no), 32'(t1_exp_no[i]));
        end
        idle(1);
        chk("t1_cnt_ov", 32'(cnt_ov), 32'd2);
        chk("t2_cnt_no", 32'(cnt_no), 32'd1);

        // Test 3: 1011 with three idle cycles between bits.
        do_reset();
        send(1'b1); idle(3);
        send(1'b0); idle(3);
        send(1'b1); idle(3);
        chk("t3_det_before", 32'(det_ov), 32'd0);
        send(1'b1);
        chk("t3_det_pulse", 32'(det_ov), 32'd1);
        idle(1);
        chk("t3_det_after", 32'(det_ov), 32'd0);
        chk("t3_cnt", 32'(cnt_ov), 32'd1);

        // Test 4: load 0110 after a partial 1,0,1; bit on the load edge is ignored.
        do_reset();
        send(1'b1); send(1'b0); send(1'b1);
        pattern      = 4'b0110;
        pattern_load = 1'b1;
        sequence_in  = 1'b1;
        in_valid     = 1'b1;
        tick();
        pattern_load = 1'b0;
        chk("t4_pat", 32'(pat_ov), 32'h6);
        chk("t4_det_load", 32'(det_ov), 32'd0);
        send(1'b1); send(1'b0); send(1'b1); send(1'b1);
        chk("t4_det_bit4", 32'(det_ov), 32'd0);
        send(1'b0);
        chk("t4_det_bit5", 32'(det_ov), 32'd1);
        idle(1);

        // Test 6: reset mid-stream restores the default and drops partials.
        send(1'b1); send(1'b0); send(1'b1);
        reset       = 1'b0;
        sequence_in = 1'b1;
        in_valid    = 1'b1;
        tick();
        chk("t6_rst_pat", 32'(pat_ov), 32'h0000000b);
        chk("t6_rst_cnt", 32'(cnt_ov), 32'd0);
        chk("t6_rst_det", 32'(det_ov), 32'd0);
        reset = 1'b1;
        send(1'b1); send(1'b0); send(1'b1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        send(1'b1);
        chk("t6_no_pulse", 32'(det_ov), 32'd0);
        idle(1);

        // Test 5: five overlapping matches saturate a 2-bit counter at 3.
        do_reset();
        send(1'b1); send(1'b0); send(1'b1); send(1'b1);
        repeat (4) begin
            send(1'b0); send(1'b1); send(1'b1);
        end
        idle(1);
        chk("t5_cnt_sat", 32'(cnt_c2), 32'd3);
        chk("t5_cnt_wide", 32'(cnt_ov), 32'd5);
        send(1'b0); send(1'b1);
        count_clr = 1'b1;
        send(1'b1);
        count_clr = 1'b0;
        chk("t5_clr_hit_cnt", 32'(cnt_c2), 32'd1);
        chk("t5_clr_hit_det", 32'(det_c2), 32'd1);
        count_clr = 1'b1;
        idle(1);
        count_clr = 1'b0;
        chk("t5_clr_only", 32'(cnt_c2), 32'd0);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
